// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the PC sequencer slice.
// Optional breakpoint support is enabled with macro PC_SEQ_BKPT_EN.
package pc_seq_pkg;

    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pc_seq_bkpt.sv
// Breakpoint compare with first-RUN-cycle exemption and a sticky hit flag.
// Instantiated by pc_sequencer only when PC_SEQ_BKPT_EN is defined.
module pc_seq_bkpt
    import pc_seq_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            in_run,
    input  logic            clear,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bkpt_addr,
    output logic            fire,
    output logic            hit
);

    // armed is low on the first RUN cycle so a run can resume from the breakpoint address
    logic armed;

    assign fire = in_run && armed && (pc == bkpt_addr);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            armed <= 1'b0;
            hit   <= 1'b0;
        end else begin
            armed <= in_run;
            if (fire)
                hit <= 1'b1;
            else if (clear)
                hit <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer FSM driving the fetch-unit PC clear/hold/branch controls.
// Define PC_SEQ_BKPT_EN to add the breakpoint port and pc_seq_bkpt instance.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             restart,
    input  logic             halt_instr,
    input  logic             branch_req,
    input  logic [PC_W-1:0]  branch_off,
    input  logic [PC_W-1:0]  pc,
`ifdef PC_SEQ_BKPT_EN
    input  logic [PC_W-1:0]  bkpt_addr,
`endif
    output logic             Init,
    output logic             Halt,
    output logic             Branch,
    output logic [PC_W-1:0]  Target,
    output logic             running,
    output logic             done,
    output logic             bkpt_hit,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t state, next_state;
    logic       step_q;
    logic       step_rise;
    logic       advance;
    logic       bkpt_fire;

    assign step_rise = step && !step_q;

`ifdef PC_SEQ_BKPT_EN
    logic bkpt_clear;

    assign bkpt_clear = (state == ST_IDLE) && !stop && (step_rise || start);

    pc_seq_bkpt u_bkpt (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .in_run    (state == ST_RUN),
        .clear     (bkpt_clear),
        .pc        (pc),
        .bkpt_addr (bkpt_addr),
        .fire      (bkpt_fire),
        .hit       (bkpt_hit)
    );
`else
    logic unused_pc;

    assign unused_pc = ^pc;
    assign bkpt_fire = 1'b0;
    assign bkpt_hit  = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= ST_INIT;
            step_q <= 1'b0;
        end else begin
            state  <= next_state;
            step_q <= step;
        end
    end

    // Halt drops only in RUN/STEP cycles that actually advance; leaving cycles keep the PC held
    always_comb begin
        next_state = state;
        Init       = 1'b0;
        Halt       = 1'b1;
        case (state)
            ST_INIT: begin
                Init       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (stop)
                    next_state = ST_IDLE;
                else if (step_rise)
                    next_state = ST_STEP;
                else if (start)
                    next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt_instr)
                    next_state = ST_DONE;
                else if (stop || bkpt_fire)
                    next_state = ST_IDLE;
                else
                    Halt = 1'b0;
            end
            ST_STEP: begin
                if (halt_instr) begin
                    next_state = ST_DONE;
                end else begin
                    Halt       = 1'b0;
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (restart)
                    next_state = ST_INIT;
            end
            default: next_state = ST_INIT;
        endcase
    end

    assign advance = ((state == ST_RUN) || (state == ST_STEP)) && !Halt;
    assign Branch  = branch_req && advance;
    assign Target  = branch_off;
    assign running = (state == ST_RUN) || (state == ST_STEP);
    assign done    = (state == ST_DONE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            instr_count <= '0;
        else if (state == ST_INIT)
            instr_count <= '0;
        else if (advance && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + 1'b1;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural fetch unit closing the PC loop.
// Breakpoint scenario is compiled in when PC_SEQ_BKPT_EN is defined.
module tb_pc_sequencer;

    localparam int SEL_INIT    = 0;
    localparam int SEL_HALT    = 1;
    localparam int SEL_BRANCH  = 2;
    localparam int SEL_TARGET  = 3;
    localparam int SEL_RUNNING = 4;
    localparam int SEL_DONE    = 5;
    localparam int SEL_BKPT    = 6;
    localparam int SEL_COUNT   = 7;
    localparam int SEL_PC      = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        start, stop, step, restart, halt_instr, branch_req;
    logic [7:0]  branch_off;
    logic [7:0]  pc;
`ifdef PC_SEQ_BKPT_EN
    logic [7:0]  bkpt_addr;
`endif
    logic        Init, Halt, Branch, running, done, bkpt_hit;
    logic [7:0]  Target;
    logic [15:0] instr_count;

    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] act;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .restart     (restart),
        .halt_instr  (halt_instr),
        .branch_req  (branch_req),
        .branch_off  (branch_off),
        .pc          (pc),
`ifdef PC_SEQ_BKPT_EN
        .bkpt_addr   (bkpt_addr),
`endif
        .Init        (Init),
        .Halt        (Halt),
        .Branch      (Branch),
        .Target      (Target),
        .running     (running),
        .done        (done),
        .bkpt_hit    (bkpt_hit),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    // Fetch unit: clear on Init, hold on Halt, otherwise PC+1 or PC+Target+1 (mod 256)
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            pc <= 8'h00;
        else if (Init)
            pc <= 8'h00;
        else if (!Halt)
            pc <= Branch ? (pc + Target + 8'd1) : (pc + 8'd1);
    end

    function automatic logic [15:0] sample(input int sel);
        case (sel)
            SEL_INIT:    return {15'b0, Init};
            SEL_HALT:    return {15'b0, Halt};
            SEL_BRANCH:  return {15'b0, Branch};
            SEL_TARGET:  return {8'b0, Target};
            SEL_RUNNING: return {15'b0, running};
            SEL_DONE:    return {15'b0, done};
            SEL_BKPT:    return {15'b0, bkpt_hit};
            SEL_COUNT:   return instr_count;
            SEL_PC:      return {8'b0, pc};
            default:     return 16'hDEAD;
        endcase
    endfunction

    // Monitor: every expectation queued in a cycle is compared at that cycle's falling edge
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = sample(cur.sel);
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", cur.name, act, cur.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic st, input logic rs,
                                 input logic hi, input logic br, input logic [7:0] off);
        start      = s;
        stop       = sp;
        step       = st;
        restart    = rs;
        halt_instr = hi;
        branch_req = br;
        branch_off = off;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    initial begin
        RST_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h00);
`ifdef PC_SEQ_BKPT_EN
        bkpt_addr = 8'h08;
`endif
        tick();
        checkOutput("rst_init", SEL_INIT, 16'd1);
        checkOutput("rst_halt", SEL_HALT, 16'd1);
        checkOutput("rst_branch", SEL_BRANCH, 16'd0);
        checkOutput("rst_count", SEL_COUNT, 16'd0);
        checkOutput("rst_running", SEL_RUNNING, 16'd0);
        checkOutput("rst_done", SEL_DONE, 16'd0);
        checkOutput("rst_bkpt", SEL_BKPT, 16'd0);
        tick();

        RST_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("init_cycle", SEL_INIT, 16'd1);
        checkOutput("init_halt", SEL_HALT, 16'd1);
        tick();
        checkOutput("idle_init", SEL_INIT, 16'd0);
        checkOutput("idle_halt", SEL_HALT, 16'd1);
        checkOutput("idle_count", SEL_COUNT, 16'd0);
        checkOutput("idle_running", SEL_RUNNING, 16'd0);
        tick();
        checkOutput("idle2_init", SEL_INIT, 16'd0);
        checkOutput("idle2_count", SEL_COUNT, 16'd0);

        // Free run for five instructions, then stop
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("idle_start_halt", SEL_HALT, 16'd1);
        tick();
        repeat (5) begin
            checkOutput("run_halt", SEL_HALT, 16'd0);
            checkOutput("run_running", SEL_RUNNING, 16'd1);
            tick();
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        checkOutput("run5_pc", SEL_PC, 16'h0005);
        checkOutput("run5_count", SEL_COUNT, 16'd5);
        checkOutput("stop_halt", SEL_HALT, 16'd1);
        checkOutput("stop_running", SEL_RUNNING, 16'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("stop_pc_hold", SEL_PC, 16'h0005);
        checkOutput("stop_idle", SEL_RUNNING, 16'd0);
        tick();

        // Branch at pc=0x10
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        repeat (11) tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h05);
        checkOutput("br_pc", SEL_PC, 16'h0010);
        checkOutput("br_branch", SEL_BRANCH, 16'd1);
        checkOutput("br_target", SEL_TARGET, 16'h0005);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        checkOutput("br_next_pc", SEL_PC, 16'h0016);
        checkOutput("br_stop_halt", SEL_HALT, 16'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h33);
        checkOutput("idle_branch_blocked", SEL_BRANCH, 16'd0);
        checkOutput("idle_target_pass", SEL_TARGET, 16'h0033);
        checkOutput("br_count", SEL_COUNT, 16'd17);
        tick();

        // Step held high: one advance only, then re-press
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        checkOutput("step_idle_halt", SEL_HALT, 16'd1);
        tick();
        checkOutput("step_adv_halt", SEL_HALT, 16'd0);
        checkOutput("step_running", SEL_RUNNING, 16'd1);
        tick();
        checkOutput("step_held_halt", SEL_HALT, 16'd1);
        checkOutput("step_held_running", SEL_RUNNING, 16'd0);
        checkOutput("step_held_pc", SEL_PC, 16'h0017);
        tick();
        checkOutput("step_held2_halt", SEL_HALT, 16'd1);
        checkOutput("step_held2_pc", SEL_PC, 16'h0017);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("step_rel_pc", SEL_PC, 16'h0017);
        checkOutput("step_rel_count", SEL_COUNT, 16'd18);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("step2_adv_halt", SEL_HALT, 16'd0);
        tick();
        checkOutput("step2_pc", SEL_PC, 16'h0018);
        checkOutput("step2_count", SEL_COUNT, 16'd19);
        checkOutput("step2_running", SEL_RUNNING, 16'd0);
        tick();

        // Halt instruction at pc=0x20, DONE ignores start/step, restart re-inits
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        repeat (8) tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 8'h04);
        checkOutput("halt_pc", SEL_PC, 16'h0020);
        checkOutput("halt_halt", SEL_HALT, 16'd1);
        checkOutput("halt_branch", SEL_BRANCH, 16'd0);
        tick();
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h00);
        checkOutput("done_flag", SEL_DONE, 16'd1);
        checkOutput("done_running", SEL_RUNNING, 16'd0);
        checkOutput("done_pc", SEL_PC, 16'h0020);
        checkOutput("done_halt", SEL_HALT, 16'd1);
        checkOutput("done_count", SEL_COUNT, 16'd27);
        tick();
        checkOutput("done_ignore_start", SEL_DONE, 16'd1);
        checkOutput("done_ignore_pc", SEL_PC, 16'h0020);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 8'h00);
        checkOutput("restart_done", SEL_DONE, 16'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("restart_init", SEL_INIT, 16'd1);
        checkOutput("restart_done_clr", SEL_DONE, 16'd0);
        tick();
        checkOutput("restart_pc", SEL_PC, 16'h0000);
        checkOutput("restart_count", SEL_COUNT, 16'd0);
        checkOutput("restart_idle_init", SEL_INIT, 16'd0);
        tick();

        // Asynchronous reset in the middle of a run
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        repeat (3) tick();
        checkOutput("mid_run_running", SEL_RUNNING, 16'd1);
        checkOutput("mid_run_pc", SEL_PC, 16'h0003);
        tick();
        RST_n      = 1'b0;
        branch_req = 1'b1;
        #1;
        checkOutput("arst_init", SEL_INIT, 16'd1);
        checkOutput("arst_halt", SEL_HALT, 16'd1);
        checkOutput("arst_branch", SEL_BRANCH, 16'd0);
        checkOutput("arst_running", SEL_RUNNING, 16'd0);
        checkOutput("arst_count", SEL_COUNT, 16'd0);
        tick();
        RST_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("arst_init_cycle", SEL_INIT, 16'd1);
        tick();
        checkOutput("arst_idle_init", SEL_INIT, 16'd0);
        checkOutput("arst_idle_pc", SEL_PC, 16'h0000);
        tick();

`ifdef PC_SEQ_BKPT_EN
        // Breakpoint at 0x08, then resume past it
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        repeat (8) tick();
        checkOutput("bkpt_pc", SEL_PC, 16'h0008);
        checkOutput("bkpt_halt", SEL_HALT, 16'd1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("bkpt_hit_set", SEL_BKPT, 16'd1);
        checkOutput("bkpt_hold_pc", SEL_PC, 16'h0008);
        checkOutput("bkpt_idle", SEL_RUNNING, 16'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("bkpt_hit_clr", SEL_BKPT, 16'd0);
        checkOutput("bkpt_exempt_halt", SEL_HALT, 16'd0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00);
        checkOutput("bkpt_resume_pc", SEL_PC, 16'h0009);
        checkOutput("bkpt_resume_running", SEL_RUNNING, 16'd1);
        checkOutput("bkpt_no_retrigger", SEL_BKPT, 16'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("bkpt_final_pc", SEL_PC, 16'h0009);
        tick();
`endif

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begin free-running fetch.
- stop  in  1  level; stop fetch.
- step  in  1  level; advance exactly one instruction.
- restart  in  1  pulse; re-initialise PC from the DONE state.
- halt_instr  in  1  decoder flags a halt instruction at the current PC.
- branch_req  in  1  decoder requests a taken branch.
- branch_off  in  8  signed branch offset from the decoder.
- pc  in  8  current PC fed back from the fetch unit.
- bkpt_addr  in  8  breakpoint address (used only when BKPT_EN is defined).
- Init  out  1  drives the fetch-unit PC clear.
- Halt  out  1  drives the fetch-unit PC hold.
- Branch  out  1  drives the fetch-unit branch select.
- Target  out  8  drives the fetch-unit branch offset.
- running  out  1  high in RUN or STEP.
- done  out  1  high in DONE.
- bkpt_hit  out  1  sticky breakpoint flag.
- instr_count  out  16  count of advanced instructions.

Function
REQ-002 The FSM SHALL have five states: INIT, IDLE, RUN, STEP, DONE, held in a 3-bit registered encoding.
- Init=1 only in INIT.
- Halt=1 in INIT, IDLE and DONE.
- Halt=0 in RUN and STEP, except in a cycle where the block leaves RUN because of halt_instr, stop or a breakpoint; Halt=1 in that same cycle, so the PC holds.
REQ-003 INIT SHALL last exactly one cycle and then go to IDLE.
REQ-004 IDLE SHALL give priority stop > step > start.
- step goes to STEP.
- start goes to RUN.
- stop, or no request, stays in IDLE.
REQ-005 STEP SHALL advance one instruction (Halt=0 for one cycle) and then return to IDLE, even if step is still held.
REQ-006 A new step SHALL require step to go low for at least one cycle (edge-qualified via a registered copy).
REQ-007 RUN SHALL give priority halt_instr > stop > breakpoint > continue.
- halt_instr goes to DONE.
- stop or a breakpoint goes to IDLE.
REQ-008 In STEP, halt_instr SHALL go to DONE with Halt=1.
REQ-009 DONE SHALL hold until restart, then go to INIT; start, step and stop SHALL be ignored in DONE.
REQ-010 Branch SHALL equal branch_req AND advance, where advance = state is RUN or STEP AND Halt=0; this output is combinational.
REQ-011 Target SHALL equal branch_off, passed through combinationally.
REQ-012 The fetch unit computes the next PC = PC + Target + 1, modulo 256; this block SHALL NOT flag or block a PC wrap from 0xFF to 0x00.
REQ-013 instr_count SHALL increment in every cycle where advance=1, saturate at 0xFFFF, and clear in INIT.
REQ-014 running and done SHALL be decoded from the state register only, with no combinational path from inputs.

Reset
REQ-015 While RST_n=0 the block SHALL hold the following values:
- state=INIT, Init=1, Halt=1, Branch=0.
- instr_count=0, bkpt_hit=0, and the step edge register=0.
REQ-016 After RST_n deasserts, the block SHALL spend exactly one further cycle in INIT.
REQ-017 A reset asserted mid-RUN SHALL immediately force the INIT outputs, asynchronously.

Configuration
REQ-018 With macro PC_SEQ_BKPT_EN defined, the breakpoint SHALL work as follows:
- It fires in RUN when pc == bkpt_addr.
- It sets bkpt_hit.
- bkpt_hit clears on the next start or step.
- The first RUN cycle after leaving IDLE is exempt from the compare, so the block can resume from the breakpoint address.
REQ-019 Without PC_SEQ_BKPT_EN, the breakpoint logic and the bkpt_addr port SHALL be absent, and bkpt_hit SHALL be tied to 0.

Structure
REQ-020 A shared package pc_seq_pkg SHALL hold:
- the state enum typedef (seq_state_t);
- PC_W=8 and CNT_W=16.
REQ-021 The block SHALL contain one sub-module, pc_seq_bkpt (breakpoint compare, exemption flag and sticky hit), instantiated only when PC_SEQ_BKPT_EN is defined.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Reset release with all requests low: Init=1 for exactly one cycle, then state IDLE with Halt=1; instr_count stays 0.
- start held for 5 cycles with no branches: pc advances 0→5 and instr_count=5. Then stop: Halt=1 in the same cycle, so pc holds at 5.
- In RUN at pc=0x10, branch_req=1 with branch_off=0x05 for one cycle: Branch=1 and Target=0x05, and the next pc=0x16. A branch_req in IDLE gives Branch=0.
- step held high for 4 cycles from IDLE: exactly one advance, pc increments by 1. Release step, then press again: one more advance.
- halt_instr at pc=0x20 in RUN: state DONE, pc stays at 0x20 and done=1. start is ignored; restart gives Init=1 and the next pc=0.
- PC_SEQ_BKPT_EN defined with bkpt_addr=0x08: running from 0 stops with pc=0x08 and bkpt_hit=1. A following start clears bkpt_hit and resumes to 0x09 without re-triggering.
